// File: rtl/array_scan_ctrl.sv
// Row-major read sequencer for the b[N0][N1][N2] / c[N1][N2] test arrays.
// Streams one element per transfer with flat index, last flag and running sum.
module array_scan_ctrl #(
    parameter int unsigned DW = 11,
    parameter int unsigned N0 = 3,
    parameter int unsigned N1 = 2,
    parameter int unsigned N2 = 4,
    parameter int unsigned SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sel,
    input  logic [DW-1:0] b [N0][N1][N2],
    input  logic [DW-1:0] c [N1][N2],
    output logic          busy,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [4:0]    o_idx,
    output logic          o_last,
    output logic [SW-1:0] sum,
    output logic          done
);

    localparam int unsigned IW = 5;
    localparam int unsigned NB = N0 * N1 * N2;
    localparam int unsigned NC = N1 * N2;
    localparam int unsigned AW = (N0 > 1) ? $clog2(N0) : 1;
    localparam int unsigned BW = (N1 > 1) ? $clog2(N1) : 1;
    localparam int unsigned CW = (N2 > 1) ? $clog2(N2) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic          sel_q;
    logic [AW-1:0] i;
    logic [BW-1:0] j;
    logic [CW-1:0] k;

    logic [AW-1:0] i_nxt_c;
    logic [AW-1:0] i_safe_c;
    logic [BW-1:0] j_nxt_c;
    logic [CW-1:0] k_nxt_c;
    logic [DW-1:0] nxt_elem_c;
    logic [DW-1:0] first_elem_c;
    logic [IW-1:0] nxt_idx_c;
    logic          nxt_last_c;
    logic          first_last_c;
    logic          xfer_c;

    // Row-major successor of (i,j,k): k fastest, then j, then i.
    always_comb begin
        i_nxt_c = i;
        j_nxt_c = j;
        k_nxt_c = k + CW'(1);
        if (k == CW'(N2 - 1)) begin
            k_nxt_c = '0;
            j_nxt_c = j + BW'(1);
            if (j == BW'(N1 - 1)) begin
                j_nxt_c = '0;
                i_nxt_c = i + AW'(1);
            end
        end
    end

    // Keep the b read in range past the final element; that value is never loaded.
    always_comb begin
        i_safe_c = i_nxt_c;
        if (32'(i_nxt_c) >= N0) begin
            i_safe_c = '0;
        end
    end

    always_comb begin
        nxt_elem_c   = sel_q ? c[j_nxt_c][k_nxt_c] : b[i_safe_c][j_nxt_c][k_nxt_c];
        first_elem_c = sel ? c[0][0] : b[0][0][0];
        nxt_idx_c    = o_idx + IW'(1);
        nxt_last_c   = (nxt_idx_c == (sel_q ? IW'(NC - 1) : IW'(NB - 1)));
        first_last_c = sel ? (NC == 1) : (NB == 1);
        xfer_c       = o_valid & o_ready;
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sel_q   <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            busy    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            sum     <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SCAN;
                        sel_q   <= sel;
                        i       <= '0;
                        j       <= '0;
                        k       <= '0;
                        sum     <= '0;
                        o_data  <= first_elem_c;
                        o_idx   <= '0;
                        o_last  <= first_last_c;
                        o_valid <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    if (xfer_c) begin
                        sum <= sum + SW'(o_data);
                        if (o_last) begin
                            state   <= DONE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            i      <= i_nxt_c;
                            j      <= j_nxt_c;
                            k      <= k_nxt_c;
                            o_data <= nxt_elem_c;
                            o_idx  <= nxt_idx_c;
                            o_last <= nxt_last_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    o_valid <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_scan_ctrl.sv
// Scoreboard bench for array_scan_ctrl: the stimulus pushes expected beats from a
// flat-index array model, and a negedge monitor pops and compares them.
module tb_array_scan_ctrl;

    localparam int unsigned DW = 11;
    localparam int unsigned N0 = 3;
    localparam int unsigned N1 = 2;
    localparam int unsigned N2 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic          o_ready = 1'b0;
    logic [DW-1:0] b [N0][N1][N2];
    logic [DW-1:0] c [N1][N2];

    logic          busy, o_valid, o_last, done;
    logic [DW-1:0] o_data;
    logic [4:0]    o_idx;
    logic [15:0]   sum;

    logic          busy12, valid12, last12, done12;
    logic [DW-1:0] data12;
    logic [4:0]    idx12;
    logic [11:0]   sum12;

    array_scan_ctrl #(.DW(DW), .N0(N0), .N1(N1), .N2(N2), .SW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .b(b), .c(c),
        .busy(busy), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_idx(o_idx), .o_last(o_last), .sum(sum), .done(done)
    );

    array_scan_ctrl #(.DW(DW), .N0(N0), .N1(N1), .N2(N2), .SW(12)) dut12 (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .b(b), .c(c),
        .busy(busy12), .o_valid(valid12), .o_ready(o_ready), .o_data(data12),
        .o_idx(idx12), .o_last(last12), .sum(sum12), .done(done12)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        int last;
        int sum16;
        int sum12;
    } beat_t;

    typedef struct {
        int nbeats;
        int sum16;
        int sum12;
    } fin_t;

    beat_t exp_q[$];
    fin_t  fin_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_seen = 0;
    int    busy_cnt = 0;
    int    stall_cnt = 0;
    beat_t mb;
    fin_t  mf;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: enumerate flat indices and decompose them arithmetically.
    task automatic push_scan(input bit s);
        int    n;
        int    run;
        beat_t bt;
        fin_t  fn;
        n   = s ? int'(N1 * N2) : int'(N0 * N1 * N2);
        run = 0;
        for (int f = 0; f < n; f++) begin
            int ii;
            int jj;
            int kk;
            ii = f / int'(N1 * N2);
            jj = (f / int'(N2)) % int'(N1);
            kk = f % int'(N2);
            bt.data  = s ? int'(c[jj][kk]) : int'(b[ii][jj][kk]);
            bt.idx   = f;
            bt.last  = (f == n - 1) ? 1 : 0;
            bt.sum16 = run % 65536;
            bt.sum12 = run % 4096;
            run += bt.data;
            exp_q.push_back(bt);
        end
        fn.nbeats = n;
        fn.sum16  = run % 65536;
        fn.sum12  = run % 4096;
        fin_q.push_back(fn);
    endtask

    // Monitor: compare every presented element against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt  = 0;
            stall_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    mb = exp_q[0];
                    chk("o_data", int'(o_data), mb.data);
                    chk("o_idx", int'(o_idx), mb.idx);
                    chk("o_last", int'(o_last), mb.last);
                    chk("sum_run", int'(sum), mb.sum16);
                    chk("data12", int'(data12), mb.data);
                    chk("idx12", int'(idx12), mb.idx);
                    chk("last12", int'(last12), mb.last);
                    chk("sum12_run", int'(sum12), mb.sum12);
                    if (o_ready) void'(exp_q.pop_front());
                    else stall_cnt++;
                end
            end
            if (done) begin
                done_seen++;
                chk("done_valid", int'(o_valid), 0);
                chk("done_valid12", int'(valid12), 0);
                chk("done12", int'(done12), 1);
                chk("done_busy", int'(busy), 1);
                chk("done_busy12", int'(busy12), 1);
                if (fin_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mf = fin_q.pop_front();
                    chk("final_sum", int'(sum), mf.sum16);
                    chk("final_sum12", int'(sum12), mf.sum12);
                    chk("busy_cycles", busy_cnt, mf.nbeats + stall_cnt + 1);
                    chk("beats_left", exp_q.size(), 0);
                end
                busy_cnt  = 0;
                stall_cnt = 0;
            end
        end
    end

    function automatic logic pick_ready(input int mode, input logic cur);
        if (mode == 1) return ~cur;
        if (mode == 2) return ($urandom % 4) != 0;
        return 1'b1;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_last"}, int'(o_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_data"}, int'(o_data), 0);
        chk({tag, "_idx"}, int'(o_idx), 0);
        chk({tag, "_sum"}, int'(sum), 0);
        chk({tag, "_sum12"}, int'(sum12), 0);
    endtask

    // mode: 0 ready high, 1 alternating, 2 random; negative idx disables that event.
    task automatic run_scan(input bit s, input int mode, input int stall_idx,
                            input int restart_idx, input int rst_idx);
        int ds;
        int held;
        int cyc;
        bit restarted;
        ds        = done_seen;
        held      = 0;
        cyc       = 0;
        restarted = 0;
        push_scan(s);
        @(posedge clk); #1;
        start   = 1'b1;
        sel     = s;
        o_ready = pick_ready(mode, o_ready);
        @(posedge clk); #1;
        start = 1'b0;
        sel   = 1'($urandom);
        while (done_seen == ds && cyc < 2000) begin
            if (rst_idx >= 0 && o_valid && int'(o_idx) == rst_idx) begin
                #2 rst = 1'b0;
                #1 check_zero_outputs("async_rst");
                exp_q.delete();
                fin_q.delete();
                @(posedge clk); #1;
                check_zero_outputs("held_rst");
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 chk("no_done_after_rst", done_seen, ds);
                return;
            end
            start = 1'b0;
            if (restart_idx >= 0 && !restarted && o_valid && int'(o_idx) == restart_idx) begin
                start     = 1'b1;
                sel       = ~s;
                restarted = 1;
            end
            if (stall_idx >= 0 && o_valid && int'(o_idx) == stall_idx && held < 5) begin
                o_ready = 1'b0;
                held++;
            end else begin
                o_ready = pick_ready(mode, o_ready);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) chk("scan_timeout", 0, 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_valid", int'(o_valid), 0);
    endtask

    initial begin
        int held_sum;
        for (int i = 0; i < int'(N0); i++)
            for (int j = 0; j < int'(N1); j++)
                for (int k = 0; k < int'(N2); k++)
                    b[i][j][k] = DW'(100 * i + 10 * j + k);
        for (int j = 0; j < int'(N1); j++)
            for (int k = 0; k < int'(N2); k++)
                c[j][k] = DW'(2047);

        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_scan(1'b0, 0, -1, -1, -1);
        chk("t1_sum", int'(sum), 2556);

        run_scan(1'b1, 0, -1, -1, -1);
        chk("t2_sum", int'(sum), 16376);

        run_scan(1'b0, 1, 6, -1, -1);
        chk("t3_sum", int'(sum), 2556);

        held_sum = done_seen;
        run_scan(1'b0, 2, -1, 10, -1);
        repeat (4) @(posedge clk);
        #1 chk("t4_single_done", done_seen, held_sum + 1);
        chk("t4_sum", int'(sum), 2556);

        run_scan(1'b0, 0, -1, -1, 5);
        run_scan(1'b1, 2, -1, -1, -1);
        chk("t5_sum", int'(sum), 16376);

        for (int i = 0; i < int'(N0); i++)
            for (int j = 0; j < int'(N1); j++)
                for (int k = 0; k < int'(N2); k++)
                    b[i][j][k] = DW'(2047);
        run_scan(1'b0, 2, -1, -1, -1);
        chk("t6_sum16", int'(sum), 49128);
        chk("t6_sum12", int'(sum12), 4072);
        repeat (3) @(posedge clk);
        #1 chk("t6_sum_hold", int'(sum), 49128);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < int'(N0); i++)
                for (int j = 0; j < int'(N1); j++)
                    for (int k = 0; k < int'(N2); k++)
                        b[i][j][k] = DW'($urandom);
            for (int j = 0; j < int'(N1); j++)
                for (int k = 0; k < int'(N2); k++)
                    c[j][k] = DW'($urandom);
            run_scan(1'($urandom), 2, int'($urandom_range(0, 7)), -1, -1);
        end

        chk("queues_empty", exp_q.size() + fin_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
